// File: rtl/control_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | control_unit                                                               |
// | Multicycle CPU control FSM: fetch, decode, execute/memory/write-back and   |
// | exception entry. Drives every datapath enable and mux select.              |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module control_unit (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       overflow,
    input  logic       branch_cond,
    output logic       PC_write,
    output logic       MEMRead,
    output logic       IRWrite,
    output logic       MDR_load,
    output logic       RegWrite,
    output logic       A_load,
    output logic       B_load,
    output logic       AluOutWrite,
    output logic       EPCWrite,
    output logic [2:0] ALU_control,
    output logic [2:0] IorD,
    output logic [1:0] RegDst,
    output logic [2:0] MemToReg,
    output logic [1:0] ALUSourceA,
    output logic [2:0] ALUSourceB,
    output logic [2:0] PCSource,
    output logic [1:0] ALULogic,
    output logic [1:0] store_control_sign,
    output logic [1:0] load_size_control,
    output logic [5:0] state
);

    localparam logic [5:0] c_OP_RTYPE = 6'h00;
    localparam logic [5:0] c_OP_J     = 6'h02;
    localparam logic [5:0] c_OP_JAL   = 6'h03;
    localparam logic [5:0] c_OP_BEQ   = 6'h04;
    localparam logic [5:0] c_OP_BNE   = 6'h05;
    localparam logic [5:0] c_OP_BLE   = 6'h06;
    localparam logic [5:0] c_OP_BGT   = 6'h07;
    localparam logic [5:0] c_OP_ADDI  = 6'h08;
    localparam logic [5:0] c_OP_LW    = 6'h23;
    localparam logic [5:0] c_OP_SW    = 6'h2B;

    localparam logic [5:0] c_FN_ADD   = 6'h20;
    localparam logic [5:0] c_FN_SUB   = 6'h22;
    localparam logic [5:0] c_FN_AND   = 6'h24;
    localparam logic [5:0] c_FN_SLT   = 6'h2A;
    localparam logic [5:0] c_FN_JR    = 6'h08;
    localparam logic [5:0] c_FN_RTE   = 6'h13;
    localparam logic [5:0] c_FN_BREAK = 6'h0D;

    localparam logic [2:0] c_ALU_PASS = 3'b000;
    localparam logic [2:0] c_ALU_ADD  = 3'b001;
    localparam logic [2:0] c_ALU_SUB  = 3'b010;
    localparam logic [2:0] c_ALU_AND  = 3'b011;
    localparam logic [2:0] c_ALU_CMP  = 3'b111;

    localparam logic [2:0] c_EXC_OPCODE   = 3'd1;
    localparam logic [2:0] c_EXC_OVERFLOW = 3'd2;

    typedef enum logic [5:0] {
        S_RESET   = 6'd0,
        S_F1      = 6'd1,
        S_F2      = 6'd2,
        S_F3      = 6'd3,
        S_DEC     = 6'd4,
        S_EX_R    = 6'd5,
        S_WB_R    = 6'd6,
        S_SLT     = 6'd7,
        S_JR      = 6'd8,
        S_RTE     = 6'd9,
        S_BREAK   = 6'd10,
        S_EX_ADDI = 6'd11,
        S_WB_ADDI = 6'd12,
        S_AD      = 6'd13,
        S_LW_M1   = 6'd14,
        S_LW_M2   = 6'd15,
        S_LW_M3   = 6'd16,
        S_LW_WB   = 6'd17,
        S_SW_M1   = 6'd18,
        S_BR      = 6'd19,
        S_JMP     = 6'd20,
        S_J1      = 6'd21,
        S_J2      = 6'd22,
        S_EXC1    = 6'd23,
        S_EXC2    = 6'd24,
        S_EXC3    = 6'd25,
        S_EXC4    = 6'd26,
        S_EXC5    = 6'd27
    } state_t;

    state_t     state_q, state_d;
    logic [2:0] exc_code_q, exc_code_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_RESET;
            exc_code_q <= 3'd0;
        end else begin
            state_q    <= state_d;
            exc_code_q <= exc_code_d;
        end
    end

    assign state = state_q;

    always_comb begin
        state_d            = state_q;
        exc_code_d         = exc_code_q;
        PC_write           = 1'b0;
        MEMRead            = 1'b0;
        IRWrite            = 1'b0;
        MDR_load           = 1'b0;
        RegWrite           = 1'b0;
        A_load             = 1'b0;
        B_load             = 1'b0;
        AluOutWrite        = 1'b0;
        EPCWrite           = 1'b0;
        ALU_control        = c_ALU_PASS;
        IorD               = 3'd0;
        RegDst             = 2'd0;
        MemToReg           = 3'd0;
        ALUSourceA         = 2'd0;
        ALUSourceB         = 3'd0;
        PCSource           = 3'd0;
        ALULogic           = 2'd0;
        store_control_sign = 2'b00;
        load_size_control  = 2'b00;

        // Reset masks every enable immediately so an aborted instruction has no side effects.
        if (!reset) begin
            case (state_q)
                S_RESET: begin
                    RegDst   = 2'd3;
                    MemToReg = 3'd3;
                    RegWrite = 1'b1;
                    state_d  = S_F1;
                end
                S_F1, S_F2: begin
                    ALUSourceB  = 3'd1;
                    ALU_control = c_ALU_ADD;
                    state_d     = (state_q == S_F1) ? S_F2 : S_F3;
                end
                S_F3: begin
                    ALUSourceB  = 3'd1;
                    ALU_control = c_ALU_ADD;
                    IRWrite     = 1'b1;
                    PC_write    = 1'b1;
                    state_d     = S_DEC;
                end
                S_DEC: begin
                    A_load      = 1'b1;
                    B_load      = 1'b1;
                    ALUSourceB  = 3'd4;
                    ALU_control = c_ALU_ADD;
                    AluOutWrite = 1'b1;
                    exc_code_d  = c_EXC_OPCODE;
                    state_d     = S_EXC1;
                    case (opcode)
                        c_OP_RTYPE: begin
                            case (funct)
                                c_FN_ADD, c_FN_SUB, c_FN_AND: state_d = S_EX_R;
                                c_FN_SLT:   state_d = S_SLT;
                                c_FN_JR:    state_d = S_JR;
                                c_FN_RTE:   state_d = S_RTE;
                                c_FN_BREAK: state_d = S_BREAK;
                                default:    state_d = S_EXC1;
                            endcase
                        end
                        c_OP_J:                               state_d = S_JMP;
                        c_OP_JAL:                             state_d = S_J1;
                        c_OP_BEQ, c_OP_BNE, c_OP_BLE, c_OP_BGT: state_d = S_BR;
                        c_OP_ADDI:                            state_d = S_EX_ADDI;
                        c_OP_LW, c_OP_SW:                     state_d = S_AD;
                        default:                              state_d = S_EXC1;
                    endcase
                end
                S_EX_R: begin
                    ALUSourceA  = 2'd1;
                    AluOutWrite = 1'b1;
                    case (funct)
                        c_FN_SUB: ALU_control = c_ALU_SUB;
                        c_FN_AND: ALU_control = c_ALU_AND;
                        default:  ALU_control = c_ALU_ADD;
                    endcase
                    // Logical AND cannot overflow; only add/sub trap.
                    if (overflow && (funct != c_FN_AND)) begin
                        exc_code_d = c_EXC_OVERFLOW;
                        state_d    = S_EXC1;
                    end else begin
                        state_d    = S_WB_R;
                    end
                end
                S_WB_R: begin
                    RegDst   = 2'd1;
                    RegWrite = 1'b1;
                    state_d  = S_F1;
                end
                S_SLT: begin
                    ALUSourceA  = 2'd1;
                    ALU_control = c_ALU_CMP;
                    RegDst      = 2'd1;
                    MemToReg    = 3'd4;
                    RegWrite    = 1'b1;
                    state_d     = S_F1;
                end
                S_JR: begin
                    PCSource = 3'd5;
                    PC_write = 1'b1;
                    state_d  = S_F1;
                end
                S_RTE: begin
                    PCSource = 3'd2;
                    PC_write = 1'b1;
                    state_d  = S_F1;
                end
                S_BREAK: begin
                    ALUSourceB  = 3'd1;
                    ALU_control = c_ALU_SUB;
                    PC_write    = 1'b1;
                    state_d     = S_F1;
                end
                S_EX_ADDI: begin
                    ALUSourceA  = 2'd1;
                    ALUSourceB  = 3'd3;
                    ALU_control = c_ALU_ADD;
                    AluOutWrite = 1'b1;
                    if (overflow) begin
                        exc_code_d = c_EXC_OVERFLOW;
                        state_d    = S_EXC1;
                    end else begin
                        state_d    = S_WB_ADDI;
                    end
                end
                S_WB_ADDI: begin
                    RegWrite = 1'b1;
                    state_d  = S_F1;
                end
                S_AD: begin
                    ALUSourceA  = 2'd1;
                    ALUSourceB  = 3'd3;
                    ALU_control = c_ALU_ADD;
                    AluOutWrite = 1'b1;
                    state_d     = (opcode == c_OP_LW) ? S_LW_M1 : S_SW_M1;
                end
                S_LW_M1, S_LW_M2: begin
                    IorD    = 3'd6;
                    state_d = (state_q == S_LW_M1) ? S_LW_M2 : S_LW_M3;
                end
                S_LW_M3: begin
                    MDR_load = 1'b1;
                    state_d  = S_LW_WB;
                end
                S_LW_WB: begin
                    MemToReg = 3'd6;
                    RegWrite = 1'b1;
                    state_d  = S_F1;
                end
                S_SW_M1: begin
                    IorD    = 3'd6;
                    MEMRead = 1'b1;
                    state_d = S_F1;
                end
                S_BR: begin
                    ALUSourceA  = 2'd1;
                    ALU_control = c_ALU_SUB;
                    PCSource    = 3'd1;
                    PC_write    = branch_cond;
                    case (opcode)
                        c_OP_BNE: ALULogic = 2'd1;
                        c_OP_BLE: ALULogic = 2'd3;
                        c_OP_BGT: ALULogic = 2'd2;
                        default:  ALULogic = 2'd0;
                    endcase
                    state_d = S_F1;
                end
                S_JMP: begin
                    PCSource = 3'd3;
                    PC_write = 1'b1;
                    state_d  = S_F1;
                end
                S_J1: begin
                    AluOutWrite = 1'b1;
                    state_d     = S_J2;
                end
                S_J2: begin
                    RegDst   = 2'd2;
                    RegWrite = 1'b1;
                    PCSource = 3'd3;
                    PC_write = 1'b1;
                    state_d  = S_F1;
                end
                S_EXC1: begin
                    ALUSourceB  = 3'd1;
                    ALU_control = c_ALU_SUB;
                    AluOutWrite = 1'b1;
                    state_d     = S_EXC2;
                end
                S_EXC2: begin
                    EPCWrite = 1'b1;
                    IorD     = exc_code_q;
                    state_d  = S_EXC3;
                end
                S_EXC3: begin
                    state_d = S_EXC4;
                end
                S_EXC4: begin
                    MDR_load = 1'b1;
                    state_d  = S_EXC5;
                end
                S_EXC5: begin
                    load_size_control = 2'b10;
                    PCSource          = 3'd4;
                    PC_write          = 1'b1;
                    state_d           = S_F1;
                end
                default: begin
                    state_d = S_RESET;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_control_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_control_unit                                                            |
// | Randomized instruction stream checked cycle by cycle against a table-built |
// | expectation of every control output. Revision: 1.0                         |
// +----------------------------------------------------------------------------+
module tb_control_unit;

    typedef struct packed {
        logic       pcw, memw, irw, mdr, rw, al, bl, aow, epcw;
        logic [2:0] alu;
        logic [2:0] iord;
        logic [1:0] rdst;
        logic [2:0] m2r;
        logic [1:0] sa;
        logic [2:0] sb;
        logic [2:0] pcs;
        logic [1:0] alog;
        logic [1:0] scs;
        logic [1:0] lsc;
    } ctl_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] opcode, funct;
    logic       overflow, branch_cond;
    logic       PC_write, MEMRead, IRWrite, MDR_load, RegWrite, A_load, B_load, AluOutWrite, EPCWrite;
    logic [2:0] ALU_control, IorD, MemToReg, ALUSourceB, PCSource;
    logic [1:0] RegDst, ALUSourceA, ALULogic, store_control_sign, load_size_control;
    logic [5:0] state;

    int   n_checks = 0;
    int   n_fail   = 0;
    ctl_t obs;
    ctl_t exp_q[$];

    control_unit dut (
        .clk(clk), .reset(reset), .opcode(opcode), .funct(funct),
        .overflow(overflow), .branch_cond(branch_cond),
        .PC_write(PC_write), .MEMRead(MEMRead), .IRWrite(IRWrite), .MDR_load(MDR_load),
        .RegWrite(RegWrite), .A_load(A_load), .B_load(B_load), .AluOutWrite(AluOutWrite),
        .EPCWrite(EPCWrite), .ALU_control(ALU_control), .IorD(IorD), .RegDst(RegDst),
        .MemToReg(MemToReg), .ALUSourceA(ALUSourceA), .ALUSourceB(ALUSourceB),
        .PCSource(PCSource), .ALULogic(ALULogic), .store_control_sign(store_control_sign),
        .load_size_control(load_size_control), .state(state)
    );

    always #5 clk = ~clk;

    always_comb obs = {PC_write, MEMRead, IRWrite, MDR_load, RegWrite, A_load, B_load,
                       AluOutWrite, EPCWrite, ALU_control, IorD, RegDst, MemToReg,
                       ALUSourceA, ALUSourceB, PCSource, ALULogic, store_control_sign,
                       load_size_control};

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
        end
    endtask

    function automatic ctl_t fetch_w();
        ctl_t w = '0;
        w.sb  = 3'd1;
        w.alu = 3'b001;
        return w;
    endfunction

    function automatic ctl_t reset_w();
        ctl_t w = '0;
        w.rdst = 2'd3;
        w.m2r  = 3'd3;
        w.rw   = 1'b1;
        return w;
    endfunction

    task automatic push_exc(input logic [2:0] code);
        ctl_t w;
        w = '0; w.sb = 3'd1; w.alu = 3'b010; w.aow = 1'b1; exp_q.push_back(w);
        w = '0; w.epcw = 1'b1; w.iord = code;             exp_q.push_back(w);
        w = '0;                                           exp_q.push_back(w);
        w = '0; w.mdr = 1'b1;                             exp_q.push_back(w);
        w = '0; w.lsc = 2'b10; w.pcs = 3'd4; w.pcw = 1'b1; exp_q.push_back(w);
    endtask

    // Expected per-cycle control words for one instruction, from F1 to its last state.
    task automatic build(input logic [5:0] op, input logic [5:0] fn, input logic ov, input logic bc);
        ctl_t w;
        exp_q.delete();
        w = fetch_w(); exp_q.push_back(w); exp_q.push_back(w);
        w.irw = 1'b1; w.pcw = 1'b1; w.pcs = 3'd0; exp_q.push_back(w);
        w = '0; w.al = 1'b1; w.bl = 1'b1; w.sb = 3'd4; w.alu = 3'b001; w.aow = 1'b1;
        exp_q.push_back(w);
        if (op == 6'h00) begin
            if (fn == 6'h20 || fn == 6'h22 || fn == 6'h24) begin
                w = '0; w.sa = 2'd1; w.aow = 1'b1;
                w.alu = (fn == 6'h20) ? 3'b001 : (fn == 6'h22) ? 3'b010 : 3'b011;
                exp_q.push_back(w);
                if (ov && fn != 6'h24) push_exc(3'd2);
                else begin w = '0; w.rdst = 2'd1; w.rw = 1'b1; exp_q.push_back(w); end
            end else if (fn == 6'h2A) begin
                w = '0; w.sa = 2'd1; w.alu = 3'b111; w.rdst = 2'd1; w.m2r = 3'd4; w.rw = 1'b1;
                exp_q.push_back(w);
            end else if (fn == 6'h08) begin
                w = '0; w.pcs = 3'd5; w.pcw = 1'b1; exp_q.push_back(w);
            end else if (fn == 6'h13) begin
                w = '0; w.pcs = 3'd2; w.pcw = 1'b1; exp_q.push_back(w);
            end else if (fn == 6'h0D) begin
                w = '0; w.sb = 3'd1; w.alu = 3'b010; w.pcw = 1'b1; exp_q.push_back(w);
            end else begin
                push_exc(3'd1);
            end
        end else if (op == 6'h02) begin
            w = '0; w.pcs = 3'd3; w.pcw = 1'b1; exp_q.push_back(w);
        end else if (op == 6'h03) begin
            w = '0; w.aow = 1'b1; exp_q.push_back(w);
            w = '0; w.rdst = 2'd2; w.rw = 1'b1; w.pcs = 3'd3; w.pcw = 1'b1; exp_q.push_back(w);
        end else if (op >= 6'h04 && op <= 6'h07) begin
            w = '0; w.sa = 2'd1; w.alu = 3'b010; w.pcs = 3'd1; w.pcw = bc;
            w.alog = (op == 6'h04) ? 2'd0 : (op == 6'h05) ? 2'd1 : (op == 6'h06) ? 2'd3 : 2'd2;
            exp_q.push_back(w);
        end else if (op == 6'h08 || op == 6'h23 || op == 6'h2B) begin
            w = '0; w.sa = 2'd1; w.sb = 3'd3; w.alu = 3'b001; w.aow = 1'b1; exp_q.push_back(w);
            if (op == 6'h08) begin
                if (ov) push_exc(3'd2);
                else begin w = '0; w.rw = 1'b1; exp_q.push_back(w); end
            end else if (op == 6'h23) begin
                w = '0; w.iord = 3'd6; exp_q.push_back(w); exp_q.push_back(w);
                w = '0; w.mdr = 1'b1; exp_q.push_back(w);
                w = '0; w.m2r = 3'd6; w.rw = 1'b1; exp_q.push_back(w);
            end else begin
                w = '0; w.iord = 3'd6; w.memw = 1'b1; exp_q.push_back(w);
            end
        end else begin
            push_exc(3'd1);
        end
    endtask

    // Called #1 after a rising edge; returns #1 after the rising edge that follows the instruction.
    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic ov,
                             input logic bc, input int abort_at);
        string tag;
        build(op, fn, ov, bc);
        for (int c = 0; c < exp_q.size(); c++) begin
            opcode      = (c < 3) ? 6'($urandom) : op;
            funct       = (c < 3) ? 6'($urandom) : fn;
            overflow    = (c == 4) ? ov : 1'($urandom);
            branch_cond = (c == 4) ? bc : 1'($urandom);
            tag = $sformatf("op%02h_fn%02h_c%0d", op, fn, c);
            if (c == abort_at) begin
                reset = 1'b1;
                @(negedge clk);
                check_eq({tag, "_abort"}, 64'(obs), 64'(0));
                @(posedge clk); #1;
                @(negedge clk);
                check_eq("abort_held_out", 64'(obs), 64'(0));
                check_eq("abort_state", 64'(state), 64'(0));
                @(posedge clk); #1;
                reset = 1'b0;
                @(negedge clk);
                check_eq("abort_reset_wb", 64'(obs), 64'(reset_w()));
                @(posedge clk); #1;
                return;
            end
            @(negedge clk);
            check_eq(tag, 64'(obs), 64'(exp_q[c]));
            @(posedge clk); #1;
        end
    endtask

    logic [5:0] legal_op [16] = '{6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h02,
                                  6'h03, 6'h04, 6'h05, 6'h06, 6'h07, 6'h08, 6'h23, 6'h2B};
    logic [5:0] legal_fn [7]  = '{6'h20, 6'h22, 6'h24, 6'h2A, 6'h08, 6'h13, 6'h0D};

    initial begin
        logic [5:0] op, fn;
        int         k;
        reset = 1'b1; opcode = '0; funct = '0; overflow = 1'b0; branch_cond = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            overflow = 1'($urandom); branch_cond = 1'($urandom);
            @(negedge clk);
            check_eq("reset_out", 64'(obs), 64'(0));
            check_eq("reset_state", 64'(state), 64'(0));
        end
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check_eq("reset_wb29", 64'(obs), 64'(reset_w()));
        @(posedge clk); #1;

        run_instr(6'h00, 6'h20, 1'b0, 1'b0, -1);  // add, no overflow
        run_instr(6'h08, 6'h11, 1'b1, 1'b0, -1);  // addi overflow -> exception code 2
        run_instr(6'h04, 6'h00, 1'b0, 1'b0, -1);  // beq not taken
        run_instr(6'h04, 6'h00, 1'b0, 1'b1, -1);  // beq taken
        run_instr(6'h23, 6'h00, 1'b0, 1'b0, -1);  // lw
        run_instr(6'h2B, 6'h00, 1'b0, 1'b0, -1);  // sw
        run_instr(6'h00, 6'h22, 1'b1, 1'b0, -1);  // sub overflow
        run_instr(6'h00, 6'h24, 1'b1, 1'b0, -1);  // and ignores overflow
        run_instr(6'h00, 6'h3E, 1'b0, 1'b0, -1);  // unknown funct
        run_instr(6'h03, 6'h00, 1'b0, 1'b0, -1);  // jal
        run_instr(6'h3F, 6'h00, 1'b0, 1'b0, 6);   // bad opcode, reset during EXC3
        run_instr(6'h00, 6'h20, 1'b0, 1'b0, 4);   // reset mid-execute

        for (int n = 0; n < 120; n++) begin
            k  = int'($urandom_range(0, 17));
            fn = 6'($urandom);
            if (k < 7) begin
                op = 6'h00; fn = legal_fn[k];
            end else if (k < 16) begin
                op = legal_op[k];
            end else begin
                op = 6'($urandom);
            end
            run_instr(op, fn, 1'($urandom), 1'($urandom), -1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
